// File: rtl/systolic_skew_feeder.sv
// Skew feeder for the systolic PE array. Lane k of the west (A) and north (B) edges is delayed
// by k cycles, and each tile is ARRAY_SIZE accepted beats followed by an ARRAY_SIZE-1 cycle zero flush.
// Defining SKEW_PERF_CNT_EN adds the tile_cnt/bubble_cnt performance counters.
module systolic_skew_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARRAY_SIZE*DATA_W-1:0] a_vec,
  input  logic [ARRAY_SIZE*DATA_W-1:0] b_vec,
  output logic [ARRAY_SIZE*DATA_W-1:0] west_a,
  output logic [ARRAY_SIZE*DATA_W-1:0] north_b,
  output logic                         tile_start,
  output logic                         tile_done,
`ifdef SKEW_PERF_CNT_EN
  output logic [31:0]                  tile_cnt,
  output logic [31:0]                  bubble_cnt,
`endif
  output logic                         busy
);

  localparam int CNT_W = $clog2(ARRAY_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(ARRAY_SIZE - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic                  r_tile_start;
  logic                  r_tile_done;
  logic                  w_accept;
  logic                  w_enter_flush;
  logic                  w_flush_last;
  logic [ARRAY_SIZE-1:0] w_lane_nz;

  // Gating with rst_n keeps every output low while reset is held.
  assign in_ready = rst_n & (r_state != S_FLUSH);
  assign w_accept = in_valid & in_ready;

  // NOTE: defaults come first so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_flush = 1'b0;
    w_flush_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_accept && (r_beat_cnt == LAST_BEAT)) begin
          w_state_nxt   = S_FLUSH;
          w_enter_flush = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == LAST_FLUSH) begin
          w_state_nxt  = S_IDLE;
          w_flush_last = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use <= so each one samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_flush_cnt  <= '0;
      r_tile_start <= 1'b0;
      r_tile_done  <= 1'b0;
    end else begin
      if (w_enter_flush) begin
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (r_state == S_FLUSH) begin
        r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + CNT_W'(1);
      end
      r_tile_start <= (r_state == S_IDLE) & w_accept;
      r_tile_done  <= w_flush_last;
    end
  end

  assign tile_start = r_tile_start;
  assign tile_done  = r_tile_done;

  // Lane k is a (k+1)-deep chain; element 0 is the input register, element k drives the edge.
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    localparam int SR_W = (k + 1) * DATA_W;
    logic [k:0][DATA_W-1:0] r_a_sr;
    logic [k:0][DATA_W-1:0] r_b_sr;
    logic [DATA_W-1:0]      w_a_in;
    logic [DATA_W-1:0]      w_b_in;

    assign w_a_in = w_accept ? a_vec[k*DATA_W +: DATA_W] : '0;
    assign w_b_in = w_accept ? b_vec[k*DATA_W +: DATA_W] : '0;

    // NOTE: these delay lines are flops, not RAM, and must read as zeros straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_sr <= '0;
        r_b_sr <= '0;
      end else begin
        r_a_sr <= SR_W'({r_a_sr, w_a_in});
        r_b_sr <= SR_W'({r_b_sr, w_b_in});
      end
    end

    assign west_a[k*DATA_W +: DATA_W]  = r_a_sr[k];
    assign north_b[k*DATA_W +: DATA_W] = r_b_sr[k];
    assign w_lane_nz[k]                = (|r_a_sr) | (|r_b_sr);
  end

  assign busy = (r_state != S_IDLE) | (|w_lane_nz);

`ifdef SKEW_PERF_CNT_EN
  logic [31:0] r_tile_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_flush_last) r_tile_cnt <= r_tile_cnt + 32'd1;
      if ((r_state == S_STREAM) && !in_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign tile_cnt   = r_tile_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a queue-based model of injected beats plus tile bookkeeping is
// compared every cycle, with literal expectations for the directed tiles.
module tb_systolic_skew_feeder;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int AW    = N * W;
  localparam int LOG_N = 4096;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] a_vec    = '0;
  logic [AW-1:0] b_vec    = '0;
  logic [AW-1:0] west_a;
  logic [AW-1:0] north_b;
  logic          tile_start;
  logic          tile_done;
  logic          busy;
`ifdef SKEW_PERF_CNT_EN
  logic [31:0]   tile_cnt;
  logic [31:0]   bubble_cnt;
`endif

  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .west_a     (west_a),
    .north_b    (north_b),
    .tile_start (tile_start),
    .tile_done  (tile_done),
`ifdef SKEW_PERF_CNT_EN
    .tile_cnt   (tile_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane %0d cycle %0d: got 0x%0h, want 0x%0h", name, lane, cyc, act, exp);
    end
  endtask

  // Behavioural model: hist_x[d] is what was injected d+1 edges ago; lane k shows hist_x[k].
  logic [AW-1:0] hist_a[$];
  logic [AW-1:0] hist_b[$];
  int            m_acc     = 0;
  int            m_fl_left = 0;
  bit            m_accept  = 1'b0;
  bit            e_start   = 1'b0;
  bit            e_done    = 1'b0;
  logic [31:0]   m_tiles   = '0;
  logic [31:0]   m_bubbles = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hist_a.delete();
      hist_b.delete();
      m_acc     = 0;
      m_fl_left = 0;
      e_start   = 1'b0;
      e_done    = 1'b0;
      m_tiles   = '0;
      m_bubbles = '0;
    end else begin
      m_accept = in_valid && (m_fl_left == 0);
      e_start  = m_accept && (m_acc == 0);
      e_done   = 1'b0;
      if ((m_acc != 0) && (m_fl_left == 0) && !in_valid) m_bubbles = m_bubbles + 32'd1;
      if (m_accept) begin
        m_acc++;
        if (m_acc == N) begin
          m_acc     = 0;
          m_fl_left = N - 1;
        end
      end else if (m_fl_left != 0) begin
        m_fl_left--;
        if (m_fl_left == 0) begin
          e_done  = 1'b1;
          m_tiles = m_tiles + 32'd1;
        end
      end
      hist_a.push_front(m_accept ? a_vec : '0);
      hist_b.push_front(m_accept ? b_vec : '0);
      if (hist_a.size() > N) begin
        void'(hist_a.pop_back());
        void'(hist_b.pop_back());
      end
    end
  end

  function automatic logic [W-1:0] lane_of(input logic [AW-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  function automatic logic [W-1:0] exp_west(input int k);
    if (k >= hist_a.size()) return '0;
    return lane_of(hist_a[k], k);
  endfunction

  function automatic logic [W-1:0] exp_north(input int k);
    if (k >= hist_b.size()) return '0;
    return lane_of(hist_b[k], k);
  endfunction

  function automatic bit exp_busy();
    bit b;
    b = (m_acc != 0) || (m_fl_left != 0);
    for (int k = 0; k < N; k++) begin
      for (int d = 0; (d <= k) && (d < hist_a.size()); d++) begin
        if ((lane_of(hist_a[d], k) != '0) || (lane_of(hist_b[d], k) != '0)) b = 1'b1;
      end
    end
    return b;
  endfunction

  logic [AW-1:0] log_west  [LOG_N];
  logic [AW-1:0] log_north [LOG_N];
  bit            log_ready [LOG_N];
  bit            log_start [LOG_N];
  bit            log_done  [LOG_N];

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("west_a", k, 32'(lane_of(west_a, k)), 32'(exp_west(k)));
      check("north_b", k, 32'(lane_of(north_b, k)), 32'(exp_north(k)));
    end
    check("in_ready", -1, 32'(in_ready), 32'(rst_n && (m_fl_left == 0)));
    check("tile_start", -1, 32'(tile_start), 32'(e_start));
    check("tile_done", -1, 32'(tile_done), 32'(e_done));
    check("busy", -1, 32'(busy), 32'(exp_busy()));
`ifdef SKEW_PERF_CNT_EN
    check("tile_cnt", -1, tile_cnt, m_tiles);
    check("bubble_cnt", -1, bubble_cnt, m_bubbles);
`endif
    if (cyc < LOG_N) begin
      log_west[cyc]  = west_a;
      log_north[cyc] = north_b;
      log_ready[cyc] = in_ready;
      log_start[cyc] = tile_start;
      log_done[cyc]  = tile_done;
    end
  end

  task automatic drive(input bit v, input logic [AW-1:0] a);
    @(negedge clk);
    in_valid = v;
    a_vec    = a;
    b_vec    = a ^ {N{8'hA5}};
  endtask

  // Directed beat pattern: lane i of relative beat r carries 0x10*r + i.
  function automatic logic [AW-1:0] pat(input int rel);
    logic [AW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(16 * rel + i);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int t2;
    t0 = 0;
    t1 = 0;
    t2 = 0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", -1, 32'(in_ready), 32'd0);
    check("reset_busy", -1, 32'(busy), 32'd0);
    #2 rst_n = 1'b1;

    // Two back-to-back tiles; valid stays high through the flush with data that must not leak.
    for (int r = 0; r <= 10; r++) begin
      drive(1'b1, pat(r));
      if (r == 0) t0 = cyc;
    end
    repeat (12) drive(1'b0, 32'hDEAD_BEEF);

    check("t0_lane2_pre", 2, 32'(lane_of(log_west[t0+2], 2)), 32'd0);
    for (int r = 0; r < 4; r++) begin
      check("t0_lane2_wave", 2, 32'(lane_of(log_west[t0+3+r], 2)), 32'(16 * r + 2));
    end
    check("t0_lane2_post", 2, 32'(lane_of(log_west[t0+7], 2)), 32'd0);
    check("t0_north2", 2, 32'(lane_of(log_north[t0+3], 2)), 32'h0000_00A7);
    check("t0_start", -1, 32'(log_start[t0+1]), 32'd1);
    check("t0_start_once", -1, 32'(log_start[t0+2]), 32'd0);
    check("t0_ready_last_beat", -1, 32'(log_ready[t0+3]), 32'd1);
    for (int r = 4; r <= 6; r++) begin
      check("t0_ready_flush", -1, 32'(log_ready[t0+r]), 32'd0);
    end
    check("t0_ready_after", -1, 32'(log_ready[t0+7]), 32'd1);
    check("t0_done_early", -1, 32'(log_done[t0+6]), 32'd0);
    check("t0_done", -1, 32'(log_done[t0+7]), 32'd1);
    check("t0_lane0_flush", 0, 32'(lane_of(log_west[t0+5], 0)), 32'd0);
    check("t0_lane3_last", 3, 32'(lane_of(log_west[t0+7], 3)), 32'h0000_0033);
    check("t0_lane3_no_mix", 3, 32'(lane_of(log_west[t0+8], 3)), 32'd0);
    check("t0_second_start", -1, 32'(log_start[t0+8]), 32'd1);
    check("t0_second_lane0", 0, 32'(lane_of(log_west[t0+8], 0)), 32'h0000_0070);

    // One bubble after beat 1.
    for (int r = 0; r < 5; r++) begin
      drive(r != 2, pat(r));
      if (r == 0) t1 = cyc;
    end
    repeat (10) drive(1'b0, '0);
    check("t1_lane0_beat1", 0, 32'(lane_of(log_west[t1+2], 0)), 32'h0000_0010);
    check("t1_lane0_bubble", 0, 32'(lane_of(log_west[t1+3], 0)), 32'd0);
    check("t1_lane0_beat2", 0, 32'(lane_of(log_west[t1+4], 0)), 32'h0000_0030);
    check("t1_ready_beat3", -1, 32'(log_ready[t1+4]), 32'd1);
    check("t1_ready_flush", -1, 32'(log_ready[t1+5]), 32'd0);
    check("t1_done_early", -1, 32'(log_done[t1+7]), 32'd0);
    check("t1_done", -1, 32'(log_done[t1+8]), 32'd1);

    // Reset in the middle of a flush.
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, pat(r));
      if (r == 0) t2 = cyc;
    end
    drive(1'b0, '0);
    drive(1'b0, '0);
    #2;
    check("busy_before_reset", -1, 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_west_a", -1, west_a, 32'd0);
    check("rst_north_b", -1, north_b, 32'd0);
    check("rst_tile_start", -1, 32'(tile_start), 32'd0);
    check("rst_tile_done", -1, 32'(tile_done), 32'd0);
    check("rst_busy", -1, 32'(busy), 32'd0);
    check("rst_in_ready", -1, 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", -1, 32'(in_ready), 32'd1);
    check("post_rst_busy", -1, 32'(busy), 32'd0);

    // Three tiles with two STREAM bubbles in total.
    for (int r = 0; r < 20; r++) drive((r != 1) && (r != 9), pat(r));
    repeat (8) drive(1'b0, '0);
`ifdef SKEW_PERF_CNT_EN
    check("perf_tile_cnt", -1, tile_cnt, 32'd3);
    check("perf_bubble_cnt", -1, bubble_cnt, 32'd2);
`endif

    // Randomised traffic, including all-zero operands and junk on idle cycles.
    repeat (1500) begin
      logic [AW-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      drive($urandom_range(0, 3) != 0, d);
    end
    drive(1'b0, '0);
    for (int i = 0; (i < 3 * N) && busy; i++) @(negedge clk);
    check("drain_busy", -1, 32'(busy), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
